cim_addr_gen: RTL and testbench

CIM_ADDR_GEN -- requirements
Module: cim_addr_gen

---
 rtl/cim_addr_gen_if.sv | 33 +++
 rtl/cim_addr_gen.sv | 160 ++++++++++++++++
 tb/tb_cim_addr_gen.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cim_addr_gen_if.sv
// rtl/cim_addr_gen_if.sv - address beat stream between the CIM address generator and its consumer
//
// Purpose: carries one bank/word address beat per valid/ready handshake.
// Ports (signals):
//   addr_valid  generator -> consumer  beat available
//   addr_ready  consumer -> generator  beat accepted when high with addr_valid
//   bank_sel    generator -> consumer  bank index of the beat
//   bank_addr   generator -> consumer  in-bank word address of the beat
//   half_sel    generator -> consumer  0 = first half, 1 = second half of a double-width element
//   elem_idx    generator -> consumer  element index the beat belongs to
// Modports: master (generator side), slave (consumer side).
interface cim_addr_gen_if #(
   parameter int BANK_W  = 2,
   parameter int BADDR_W = 14,
   parameter int LEN_W   = 7
);
   logic               addr_valid;
   logic               addr_ready;
   logic [BANK_W-1:0]  bank_sel;
   logic [BADDR_W-1:0] bank_addr;
   logic               half_sel;
   logic [LEN_W-1:0]   elem_idx;

   modport master (
      output addr_valid, bank_sel, bank_addr, half_sel, elem_idx,
      input  addr_ready
   );

   modport slave (
      input  addr_valid, bank_sel, bank_addr, half_sel, elem_idx,
      output addr_ready
   );
endinterface

// File: rtl/cim_addr_gen.sv
// rtl/cim_addr_gen.sv - strided bank/word address walker for a banked CIM memory
//
// Purpose: walks len elements starting at base_addr with a fixed stride over a
// flat space of NUM_BANKS*BANK_SIZE_NUM_WORD words, emitting each address as a
// (bank, in-bank word) pair. Double-width elements take two consecutive words.
// Optional feature macro: CIM_ADDR_GEN_DOUBLE_WIDTH_EN enables the width input;
// without it every walk is single width and half_sel is tied 0.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            one-cycle walk request, honoured only when idle
//   clear            synchronous abort back to idle, no done pulse
//   base_addr        flat start address
//   stride           flat increment between elements
//   len              number of elements (0 gives an immediate done)
//   width            0 = single width, 1 = double width
//   busy             high while the walk is running
//   done             one-cycle pulse after the walk completes
//   beat             address beat stream (master side)
module cim_addr_gen #(
   parameter int NUM_BANKS          = 4,
   parameter int BANK_SIZE_NUM_WORD = 14336,
   parameter int LEN_W              = 7,
   localparam int ADDR_W  = $clog2(NUM_BANKS*BANK_SIZE_NUM_WORD),
   localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int BADDR_W = $clog2(BANK_SIZE_NUM_WORD)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              clear,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic [LEN_W-1:0]  len,
   input  logic              width,
   output logic              busy,
   output logic              done,
   cim_addr_gen_if.master    beat
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int unsigned TOTAL = NUM_BANKS * BANK_SIZE_NUM_WORD;
   localparam int unsigned BSZ   = BANK_SIZE_NUM_WORD;
   localparam logic [BADDR_W:0] BSZ_W = (BADDR_W+1)'(BANK_SIZE_NUM_WORD);
   localparam logic [BANK_W:0]  NB_W  = (BANK_W+1)'(NUM_BANKS);

   // Splits a flat address into (bank, word). Only used when latching a new
   // walk, so the constant divide never sits between a register and an output.
   function automatic logic [BANK_W+BADDR_W-1:0] split(input logic [ADDR_W-1:0] flat);
      int unsigned m;
      m = 32'(flat) % TOTAL;
      split = {BANK_W'(m / BSZ), BADDR_W'(m % BSZ)};
   endfunction

   // Adds two (bank, word) pairs modulo the whole memory: one conditional
   // subtract per field is enough because both operands are already reduced.
   function automatic logic [BANK_W+BADDR_W-1:0] add_pair(
      input logic [BANK_W-1:0]  b,
      input logic [BADDR_W-1:0] o,
      input logic [BANK_W-1:0]  sb,
      input logic [BADDR_W-1:0] so
   );
      logic [BADDR_W:0] os;
      logic [BANK_W:0]  bs;
      os = {1'b0, o} + {1'b0, so};
      bs = {1'b0, b} + {1'b0, sb};
      if (os >= BSZ_W) begin
         os = os - BSZ_W;
         bs = bs + (BANK_W+1)'(1);
      end
      if (bs >= NB_W) bs = bs - NB_W;
      add_pair = {BANK_W'(bs), BADDR_W'(os)};
   endfunction

   logic [1:0]         state_q;
   logic [BANK_W-1:0]  sbank_q, ebank_q, obank_q;
   logic [BADDR_W-1:0] soff_q, eoff_q, ooff_q;
   logic [LEN_W-1:0]   len_q, idx_q;
   logic               width_q, half_q;

   logic [BANK_W+BADDR_W-1:0] base_split, stride_split, next_elem, next_half;
   logic accept, last_beat, width_eff;

   assign base_split   = split(base_addr);
   assign stride_split = split(stride);
   // e*_q hold the first word of the current element; o*_q is the beat on the bus.
   assign next_elem    = add_pair(ebank_q, eoff_q, sbank_q, soff_q);
   assign next_half    = add_pair(ebank_q, eoff_q, '0, BADDR_W'(1));
   assign accept       = (state_q == S_RUN) && beat.addr_ready;
   assign last_beat    = (idx_q == len_q - LEN_W'(1)) && (!width_q || half_q);

`ifdef CIM_ADDR_GEN_DOUBLE_WIDTH_EN
   assign width_eff     = width;
   assign beat.half_sel = half_q;
`else
   logic unused_width;
   assign unused_width  = width;
   assign width_eff     = 1'b0;
   assign beat.half_sel = 1'b0;
`endif

   assign beat.addr_valid = (state_q == S_RUN);
   assign beat.bank_sel   = obank_q;
   assign beat.bank_addr  = ooff_q;
   assign beat.elem_idx   = idx_q;
   assign busy            = (state_q == S_RUN);
   assign done            = (state_q == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sbank_q <= '0;
         soff_q  <= '0;
         ebank_q <= '0;
         eoff_q  <= '0;
         obank_q <= '0;
         ooff_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         width_q <= 1'b0;
         half_q  <= 1'b0;
      end else if (clear) begin
         state_q <= S_IDLE;
         half_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_q              <= len;
                  width_q            <= width_eff;
                  {sbank_q, soff_q}  <= stride_split;
                  {ebank_q, eoff_q}  <= base_split;
                  {obank_q, ooff_q}  <= base_split;
                  idx_q              <= '0;
                  half_q             <= 1'b0;
                  state_q            <= (len == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (last_beat) begin
                     state_q <= S_DONE;
                  end else if (width_q && !half_q) begin
                     {obank_q, ooff_q} <= next_half;
                     half_q            <= 1'b1;
                  end else begin
                     {ebank_q, eoff_q} <= next_elem;
                     {obank_q, ooff_q} <= next_elem;
                     idx_q             <= idx_q + LEN_W'(1);
                     half_q            <= 1'b0;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cim_addr_gen.sv
// tb/tb_cim_addr_gen.sv - self-checking bench for cim_addr_gen against a flat-address model
module tb_cim_addr_gen;
   localparam int NB    = 4;
   localparam int BSZ   = 14336;
   localparam int TOTAL = NB * BSZ;
`ifdef CIM_ADDR_GEN_DOUBLE_WIDTH_EN
   localparam bit DW = 1'b1;
`else
   localparam bit DW = 1'b0;
`endif

   typedef struct {
      int bank;
      int addr;
      int half;
      int idx;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] stride = '0;
   logic [6:0]  len = '0;
   logic        width = 1'b0;
   logic        busy, done;

   cim_addr_gen_if #(.BANK_W(2), .BADDR_W(14), .LEN_W(7)) beat ();

   cim_addr_gen #(.NUM_BANKS(NB), .BANK_SIZE_NUM_WORD(BSZ), .LEN_W(7)) dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear),
      .base_addr(base_addr), .stride(stride), .len(len), .width(width),
      .busy(busy), .done(done), .beat(beat)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int done_cnt = 0;
   bit walking  = 0;
   bit done_now = 0;
   beat_t exp_q[$];
   beat_t got[$];
   int    got_cyc[$];

   task automatic chk(input string name, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Builds the full list of beats a walk must produce from the flat-address rule.
   task automatic build_walk(input int b, input int s, input int l, input bit w);
      longint flat;
      for (int i = 0; i < l; i++) begin
         flat = (longint'(b) + longint'(i) * longint'(s)) % TOTAL;
         exp_q.push_back('{int'(flat / BSZ), int'(flat % BSZ), 0, i});
         if (w && DW) begin
            flat = (flat + 1) % TOTAL;
            exp_q.push_back('{int'(flat / BSZ), int'(flat % BSZ), 1, i});
         end
      end
   endtask

   always @(negedge clk) begin
      bit done_next;
      if (rst) begin
         chk("rst_valid", beat.addr_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_half", beat.half_sel, 0);
         chk("rst_bank", beat.bank_sel, 0);
         chk("rst_addr", beat.bank_addr, 0);
         chk("rst_idx", beat.elem_idx, 0);
         exp_q.delete();
         walking  = 0;
         done_now = 0;
      end else begin
         chk("valid", beat.addr_valid, walking);
         chk("busy", busy, walking);
         chk("done", done, done_now);
         if (done) done_cnt++;
         if (walking && exp_q.size() > 0) begin
            chk("bank_sel", beat.bank_sel, exp_q[0].bank);
            chk("bank_addr", beat.bank_addr, exp_q[0].addr);
            chk("half_sel", beat.half_sel, exp_q[0].half);
            chk("elem_idx", beat.elem_idx, exp_q[0].idx);
         end
         done_next = 0;
         if (clear) begin
            walking = 0;
            exp_q.delete();
         end else if (!walking && !done_now && start) begin
            build_walk(int'(base_addr), int'(stride), int'(len), width);
            if (exp_q.size() == 0) done_next = 1;
            else walking = 1;
         end else if (walking && beat.addr_ready) begin
            got.push_back('{int'(beat.bank_sel), int'(beat.bank_addr),
                            int'(beat.half_sel), int'(beat.elem_idx)});
            got_cyc.push_back(cyc);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               walking   = 0;
               done_next = 1;
            end
         end
         done_now = done_next;
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pin_beat(input string name, input int k, input int b, input int a, input int h, input int i);
      if (k >= got.size()) begin
         chk({name, "_missing"}, got.size(), k + 1);
      end else begin
         chk({name, "_bank"}, got[k].bank, b);
         chk({name, "_addr"}, got[k].addr, a);
         chk({name, "_half"}, got[k].half, h);
         chk({name, "_idx"},  got[k].idx,  i);
      end
   endtask

   // mode 0: ready always high, 1: ready toggles, 2: ready random
   task automatic walk(input int b, input int s, input int l, input bit w, input int mode,
                       output int g0, output int d0);
      int c;
      g0 = got.size();
      d0 = done_cnt;
      base_addr = 16'(b); stride = 16'(s); len = 7'(l); width = w;
      beat.addr_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      base_addr = 16'($urandom); stride = 16'($urandom); len = 7'($urandom); width = ~w;
      c = 0;
      while ((walking || done_now) && c < 400) begin
         case (mode)
            0: beat.addr_ready = 1'b1;
            1: beat.addr_ready = c[0];
            default: beat.addr_ready = ($urandom_range(0, 3) != 0);
         endcase
         step();
         c++;
      end
      if (c >= 400) chk("walk_timeout", c, 0);
   endtask

   task automatic abort_walk(input bit use_rst);
      int g0, d0, c;
      g0 = got.size();
      d0 = done_cnt;
      base_addr = 16'd100; stride = 16'd3; len = 7'd5; width = 1'b0;
      beat.addr_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      c = 0;
      while (got.size() < g0 + 2 && c < 50) begin
         step();
         c++;
      end
      if (c >= 50) chk("abort_timeout", c, 0);
      if (use_rst) rst = 1'b1;
      else clear = 1'b1;
      start = 1'b1; len = 7'd1;
      step();
      rst = 1'b0; clear = 1'b0; start = 1'b0;
      repeat (3) step();
      chk(use_rst ? "rst_abort_beats" : "clr_abort_beats", got.size() - g0, 2);
      chk(use_rst ? "rst_abort_done" : "clr_abort_done", done_cnt - d0, 0);
      chk(use_rst ? "rst_abort_busy" : "clr_abort_busy", busy, 0);
   endtask

   initial begin
      int g0, d0, c;
      beat.addr_ready = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();

      // Base 0, stride 1, three single beats back to back.
      walk(0, 1, 3, 1'b0, 0, g0, d0);
      pin_beat("b030_0", g0 + 0, 0, 0, 0, 0);
      pin_beat("b030_1", g0 + 1, 0, 1, 0, 1);
      pin_beat("b030_2", g0 + 2, 0, 2, 0, 2);
      if (got_cyc.size() >= g0 + 3) chk("b030_back_to_back", got_cyc[g0 + 2] - got_cyc[g0], 2);
      chk("b030_done_once", done_cnt - d0, 1);

      // Bank boundary, double width when enabled.
      walk(14335, 1, 2, 1'b1, 0, g0, d0);
      if (DW) begin
         chk("b031_count", got.size() - g0, 4);
         pin_beat("b031_0", g0 + 0, 0, 14335, 0, 0);
         pin_beat("b031_1", g0 + 1, 1, 0, 1, 0);
         pin_beat("b031_2", g0 + 2, 1, 0, 0, 1);
         pin_beat("b031_3", g0 + 3, 1, 1, 1, 1);
      end else begin
         chk("b035_count", got.size() - g0, 2);
         pin_beat("b035_0", g0 + 0, 0, 14335, 0, 0);
         pin_beat("b035_1", g0 + 1, 1, 0, 0, 1);
      end
      chk("b031_done_once", done_cnt - d0, 1);

      // Wrap past the top of the memory.
      walk(57343, 64, 2, 1'b0, 0, g0, d0);
      pin_beat("b032_0", g0 + 0, 3, 14335, 0, 0);
      pin_beat("b032_1", g0 + 1, 0, 63, 0, 1);

      // Stalls every other cycle.
      walk(777, 5000, 4, 1'b0, 1, g0, d0);
      chk("b033_count", got.size() - g0, 4);
      chk("b033_done_once", done_cnt - d0, 1);

      // Zero-length walk.
      walk(5, 1, 0, 1'b0, 0, g0, d0);
      chk("len0_beats", got.size() - g0, 0);
      chk("len0_done_once", done_cnt - d0, 1);

      abort_walk(1'b0);
      abort_walk(1'b1);

      // Randomized walks with stray starts, clears and resets.
      for (int n = 0; n < 60; n++) begin
         base_addr = 16'($urandom);
         stride = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 70)) : 16'($urandom);
         len = 7'($urandom_range(0, 9));
         width = 1'($urandom);
         beat.addr_ready = ($urandom_range(0, 3) != 0);
         start = 1'b1;
         step();
         start = 1'b0;
         c = 0;
         while ((walking || done_now) && c < 400) begin
            beat.addr_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 7) == 0);
            base_addr = 16'($urandom); stride = 16'($urandom); len = 7'($urandom); width = 1'($urandom);
            clear = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
            rst = 1'b0; clear = 1'b0; start = 1'b0;
            c++;
         end
         if (c >= 400) chk("rand_timeout", c, 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
